// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter merging an instruction port and a data port onto one non-pipelined memory command port
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_cmd_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rdata_valid,
    input  logic              d_cmd_start,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_cmd_write,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_cmd_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rdata_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cmd_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;
    state_t r_state, w_next;
    logic   r_last_d, r_owner_d;
    logic   w_grant_i, w_grant_d, w_accept, w_resp;
    // Arbitration, next state and handshake outputs; the port not granted last wins a tie
    always_comb begin
        w_grant_i     = i_cmd_start && (!d_cmd_start || r_last_d);
        w_grant_d     = d_cmd_start && !w_grant_i;
        w_accept      = (r_state == IDLE) && (w_grant_i || w_grant_d);
        w_resp        = (r_state == WAIT_R) && mem_rdata_valid;
        i_cmd_ready   = rst_n && (r_state == IDLE);
        d_cmd_ready   = rst_n && (r_state == IDLE);
        mem_cmd_start = (r_state == ISSUE);
        w_next        = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ISSUE : IDLE;
            ISSUE:   w_next = mem_cmd_ready ? (mem_cmd_write ? IDLE : WAIT_R) : ISSUE;
            WAIT_R:  w_next = mem_rdata_valid ? IDLE : WAIT_R;
            default: w_next = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Request latch on acceptance and one-cycle read response to the owning port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d      <= 1'b1;
            r_owner_d     <= 1'b0;
            mem_addr      <= '0;
            mem_cmd_write <= 1'b0;
            mem_wdata     <= '0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            i_rdata_valid <= 1'b0;
            d_rdata_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_d      <= w_grant_d;
                r_owner_d     <= w_grant_d;
                mem_addr      <= w_grant_d ? d_addr : i_addr;
                mem_cmd_write <= w_grant_d && d_cmd_write;
                mem_wdata     <= w_grant_d ? d_wdata : '0;
            end
            if (w_resp && !r_owner_d) i_rdata <= mem_rdata;
            if (w_resp && r_owner_d)  d_rdata <= mem_rdata;
            i_rdata_valid <= w_resp && !r_owner_d;
            d_rdata_valid <= w_resp && r_owner_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a transaction-level model of the arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_cmd_start = 1'b0, d_cmd_start = 1'b0, d_cmd_write = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        mem_cmd_ready = 1'b0, mem_rdata_valid = 1'b0;
    logic        i_cmd_ready, i_rdata_valid, d_cmd_ready, d_rdata_valid, mem_cmd_start, mem_cmd_write;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_start(i_cmd_start), .i_addr(i_addr), .i_cmd_ready(i_cmd_ready),
        .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
        .d_cmd_start(d_cmd_start), .d_addr(d_addr), .d_cmd_write(d_cmd_write),
        .d_wdata(d_wdata), .d_cmd_ready(d_cmd_ready), .d_rdata(d_rdata),
        .d_rdata_valid(d_rdata_valid),
        .mem_cmd_ready(mem_cmd_ready), .mem_cmd_start(mem_cmd_start), .mem_addr(mem_addr),
        .mem_cmd_write(mem_cmd_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic wr; logic [31:0] wdata;} cmd_t;
    cmd_t        cmd_q[$];
    bit          resp_q[$];
    logic [31:0] seen_q[$];
    int          checks = 0, errors = 0, cyc = 0, ph = 0;
    bit          last_d = 1'b1, own_d = 1'b0, cur_wr = 1'b0, acc_i = 1'b0, acc_d = 1'b0, run = 1'b0;
    logic [31:0] ei = '0, ed = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ph = 0; last_d = 1'b1; acc_i = 1'b0; acc_d = 1'b0; ei = '0; ed = '0;
        cmd_q.delete(); resp_q.delete();
    endtask

    // Transaction model: one request in flight, tie goes to the port not granted last
    task automatic model_edge();
        acc_i = 1'b0; acc_d = 1'b0;
        if (!rst_n) begin model_reset(); return; end
        if (ph == 0) begin
            if (i_cmd_start && (!d_cmd_start || last_d)) begin
                cmd_q.push_back('{i_addr, 1'b0, 32'h0});
                own_d = 1'b0; cur_wr = 1'b0; last_d = 1'b0; acc_i = 1'b1; ph = 1;
            end else if (d_cmd_start) begin
                cmd_q.push_back('{d_addr, d_cmd_write, d_wdata});
                own_d = 1'b1; cur_wr = d_cmd_write; last_d = 1'b1; acc_d = 1'b1; ph = 1;
            end
        end else if (ph == 1) begin
            if (mem_cmd_ready) ph = cur_wr ? 0 : 2;
        end else if (mem_rdata_valid) begin
            resp_q.push_back(own_d);
            if (own_d) ed = mem_rdata; else ei = mem_rdata;
            ph = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic drv(input bit is, input logic [31:0] ia, input bit ds, input logic [31:0] da,
                       input bit dw, input logic [31:0] dd, input bit mr, input bit mv, input logic [31:0] md);
        i_cmd_start = is; i_addr = ia; d_cmd_start = ds; d_addr = da; d_cmd_write = dw; d_wdata = dd;
        mem_cmd_ready = mr; mem_rdata_valid = mv; mem_rdata = md;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_mem_cmd_start", mem_cmd_start, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_cmd_write", mem_cmd_write, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_i_rdata_valid", i_rdata_valid, 0);
        chk("rst_d_rdata_valid", d_rdata_valid, 0);
        chk("rst_i_cmd_ready", i_cmd_ready, 0);
        chk("rst_d_cmd_ready", d_cmd_ready, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle handshake checks plus scoreboard pops on command and response
    always @(negedge clk) begin
        if (run) begin
            chk("i_cmd_ready", i_cmd_ready, rst_n && ph == 0);
            chk("d_cmd_ready", d_cmd_ready, rst_n && ph == 0);
            chk("mem_cmd_start", mem_cmd_start, ph == 1);
            chk("i_rdata", i_rdata, ei);
            chk("d_rdata", d_rdata, ed);
            if (resp_q.size() > 0) begin
                chk("i_rdata_valid", i_rdata_valid, !resp_q[0]);
                chk("d_rdata_valid", d_rdata_valid, resp_q[0]);
                void'(resp_q.pop_front());
            end else begin
                chk("i_rdata_valid", i_rdata_valid, 0);
                chk("d_rdata_valid", d_rdata_valid, 0);
            end
            if (mem_cmd_start && cmd_q.size() > 0) begin
                chk("mem_addr", mem_addr, cmd_q[0].addr);
                chk("mem_cmd_write", mem_cmd_write, cmd_q[0].wr);
                chk("mem_wdata", mem_wdata, cmd_q[0].wdata);
                if (mem_cmd_ready) begin
                    seen_q.push_back(mem_addr);
                    void'(cmd_q.pop_front());
                end
            end else if (mem_cmd_start) begin
                chk("stray_cmd", mem_cmd_start, 0);
            end
        end
    end

    initial begin
        bit          ri = 1'b0, rd = 1'b0, rdw = 1'b0;
        logic [31:0] ria = '0, rda = '0, rdd = '0;
        run = 1'b1;
        #1;
        do_reset();
        // I read 0x100 with data two cycles later, then a D read in the i_rdata_valid cycle
        drv(1, 32'h100, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("i_rdata_deadbeef", i_rdata, 32'hDEADBEEF);
        drv(0, 0, 1, 32'h200, 0, 32'h9, 1, 0, 0);
        chk("b2b_mem_cmd_start", mem_cmd_start, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("d_rdata_b2b", d_rdata, 32'h12345678);
        // D write held until downstream accepts
        drv(0, 0, 1, 32'hF000_0000, 1, 32'h41, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // D read stalled five cycles downstream, stale responses during the stall
        drv(0, 0, 1, 32'hA0, 0, 32'h55, 0, 0, 0);
        for (int k = 0; k < 5; k++) drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0 + k);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Both ports held from reset exit: grants alternate I, D, I, D
        drv(1, 32'h111, 1, 32'h222, 1, 32'h33, 1, 1, 32'h77);
        do_reset();
        seen_q.delete();
        for (int k = 0; k < 12; k++) drv(1, 32'h111, 1, 32'h222, 1, 32'h33, 1, 1, 32'h70 + k);
        chk("rr_count", seen_q.size() >= 4, 1);
        if (seen_q.size() >= 4) begin
            chk("rr_grant0", seen_q[0], 32'h111);
            chk("rr_grant1", seen_q[1], 32'h222);
            chk("rr_grant2", seen_q[2], 32'h111);
            chk("rr_grant3", seen_q[3], 32'h222);
        end
        drv(0, 0, 0, 0, 0, 0, 1, 1, 32'h1);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 32'h2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset while waiting for read data, late response dropped, then a normal read
        drv(1, 32'h300, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);
        drv(1, 32'h304, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h600D);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("i_rdata_after_reset", i_rdata, 32'h600D);
        // Random traffic: requests held until the model accepts them
        for (int n = 0; n < 4000; n++) begin
            if (acc_i) ri = 1'b0;
            if (acc_d) rd = 1'b0;
            if (!ri && $urandom_range(3) == 0) begin ri = 1'b1; ria = $urandom; end
            if (!rd && $urandom_range(3) == 0) begin
                rd = 1'b1; rda = $urandom; rdw = 1'($urandom_range(1)); rdd = $urandom;
            end
            if ($urandom_range(299) == 0) do_reset();
            drv(ri, ria, rd, rda, rdw, rdd, $urandom_range(2) != 0, $urandom_range(2) == 0, $urandom);
        end
        for (int k = 0; k < 10; k++) drv(0, 0, 0, 0, 0, 0, 1, 1, $urandom);
        chk("drain_i_cmd_ready", i_cmd_ready, 1);
        chk("drain_d_cmd_ready", d_cmd_ready, 1);
        @(negedge clk);
        #1;
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
